// File: rtl/one_word_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : one_word_sync_pkg
// Purpose  : Shared constants for the one-word CDC holder controllers.
// Revision : 1.0 - initial release
// ============================================================================
package one_word_sync_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam int DWID_DEF  = 32;
    localparam int CNT_W_DEF = 16;

endpackage : one_word_sync_pkg
`default_nettype wire

// File: rtl/one_word_pop_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : one_word_pop_ctrl_if
// Purpose  : Holder pop handshake plus downstream valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
interface one_word_pop_ctrl_if
    import one_word_sync_pkg::*;
#(
    parameter int DWID = DWID_DEF
);

    logic            sync_pop_empty;
    logic [DWID-1:0] sync_data;
    logic            sync_pop_req;
    logic            m_valid;
    logic            m_ready;
    logic [DWID-1:0] m_data;

    modport master (
        input  sync_pop_empty, sync_data, m_ready,
        output sync_pop_req, m_valid, m_data
    );

    modport slave (
        output sync_pop_empty, sync_data, m_ready,
        input  sync_pop_req, m_valid, m_data
    );

endinterface : one_word_pop_ctrl_if
`default_nettype wire

// File: rtl/ow_pop_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ow_pop_fifo
// Purpose  : DEPTH-entry synchronous FIFO with flush and fall-through head.
// Revision : 1.0 - initial release
// ============================================================================
module ow_pop_fifo #(
    parameter int DWID  = 32,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     wr_en,
    input  wire logic [DWID-1:0]          wr_data,
    input  wire logic                     rd_en,
    input  wire logic                     flush,
    output logic [$clog2(DEPTH):0]        cnt,
    output logic                          valid,
    output logic [DWID-1:0]               rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWID-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_cnt;

    // Flush outranks a same-cycle write so a colliding capture is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign cnt     = r_cnt;
    assign valid   = (r_cnt != '0);
    assign rd_data = r_mem[r_rd_ptr];

endmodule : ow_pop_fifo
`default_nettype wire

// File: rtl/one_word_pop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : one_word_pop_ctrl
// Purpose  : Pop-side controller: drains the one-word holder into a local FIFO,
//            one pop pulse per word. ONE_WORD_POP_CNT_EN adds pop_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module one_word_pop_ctrl
    import one_word_sync_pkg::*;
#(
    parameter int DWID  = DWID_DEF,
    parameter int DEPTH = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    one_word_pop_ctrl_if.master       bus,
    input  wire logic                 flush,
    output logic [$clog2(DEPTH):0]    fifo_cnt
`ifdef ONE_WORD_POP_CNT_EN
    ,
    output logic [CNT_W-1:0]          pop_cnt
`endif
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_fifo_rd;
    logic       w_space;
    logic       w_capture;

    assign w_fifo_rd = bus.m_valid & bus.m_ready;
    // A full FIFO still has room when the head leaves in the same cycle.
    assign w_space   = (fifo_cnt < C_DEPTH) || w_fifo_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!bus.sync_pop_empty && w_space) w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The pop pulse is the ACK state bit itself, so reset clears it at once.
    always_comb begin
        w_capture        = (r_state == ST_IDLE) && !bus.sync_pop_empty && w_space;
        bus.sync_pop_req = (r_state == ST_ACK);
    end

    ow_pop_fifo #(
        .DWID    (DWID),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_capture),
        .wr_data (bus.sync_data),
        .rd_en   (w_fifo_rd),
        .flush   (flush),
        .cnt     (fifo_cnt),
        .valid   (bus.m_valid),
        .rd_data (bus.m_data)
    );

`ifdef ONE_WORD_POP_CNT_EN
    logic [CNT_W-1:0] r_pop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_cnt <= '0;
        end else if (bus.sync_pop_req) begin
            r_pop_cnt <= r_pop_cnt + CNT_W'(1);
        end
    end

    assign pop_cnt = r_pop_cnt;
`endif

endmodule : one_word_pop_ctrl
`default_nettype wire

// File: doc/one_word_pop_ctrl.md
Name: one_word_pop_ctrl

Overview:
Pop-side controller for the one-word clock-domain-crossing holder, running entirely in the pop clock domain. It watches the holder's empty flag and captures each delivered word into a small local FIFO. It returns exactly one single-cycle pop request per word so the push side can release its full flag. Downstream logic sees a plain valid/ready stream and never handles the holder's pop handshake directly.

Parameters:
DWID, 32, word width; must match the holder's DWID.
DEPTH, 2, local FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the optional popped-word counter.

Ports:
clk  input  1  pop-domain clock.
rst_n  input  1  asynchronous active-low reset.
sync_pop_empty  input  1  holder empty flag; 0 means sync_data holds an unconsumed word.
sync_data  input  DWID  holder data output; stable while sync_pop_empty=0.
sync_pop_req  output  1  registered single-cycle pop pulse to the holder.
flush  input  1  synchronous clear of the local FIFO.
m_valid  output  1  FIFO head valid.
m_ready  input  1  downstream accept.
m_data  output  DWID  FIFO head data.
fifo_cnt  output  $clog2(DEPTH)+1  current occupancy.
pop_cnt  output  CNT_W  total words popped; present only with ONE_WORD_POP_CNT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset values: sync_pop_req=0, m_valid=0, m_data=0, fifo_cnt=0, pop_cnt=0, FSM=IDLE, read/write pointers=0.
- FSM has two states, IDLE and ACK.
- IDLE -> ACK on a cycle where sync_pop_empty=0 and there is space. Space means fifo_cnt<DEPTH, or fifo_cnt==DEPTH with an m_valid&m_ready handshake in the same cycle.
- On the IDLE->ACK edge: sync_data is written into the FIFO and sync_pop_req is registered high.
- ACK -> IDLE unconditionally after 1 cycle. sync_pop_req returns to 0.
- sync_pop_req is therefore high for exactly 1 cycle per word. It is never high in two consecutive cycles.
- The holder drops its valid at the end of the ACK cycle, so IDLE sees sync_pop_empty=1 and no double capture occurs.
- Latency: if sync_pop_empty falls in cycle T, m_valid rises in T+1, sync_pop_req is high in T+1, and sync_pop_empty rises in T+2. Best case is 1 word per 2 cycles.
- FIFO full with sync_pop_empty=0 and no downstream accept: stay in IDLE with sync_pop_req=0. The word stays in the holder, so the push side stays blocked (backpressure).
- Stream output: m_data is the FIFO head, taken combinationally from the storage array. m_valid = (fifo_cnt!=0).
- Same-cycle FIFO write and read: fifo_cnt is unchanged and the pointers advance independently. Pointers wrap modulo DEPTH.
- Occupancy: fifo_cnt never exceeds DEPTH. Reads at fifo_cnt=0 are impossible because m_valid=0.
- flush=1: the FIFO empties next cycle (pointers=0, fifo_cnt=0, m_valid=0).
  - A capture in the same cycle as flush is discarded, but the FSM still goes to ACK and pulses sync_pop_req, so the holder is drained.
  - flush in ACK does not cancel the pending sync_pop_req.
- Reset mid-operation:
  - Asserting rst_n during ACK clears sync_pop_req immediately.
  - The holder may still show the word after reset release; it is recaptured from IDLE.
  - The pop domain is reset together with the holder's pop side.

Optional Feature:
ONE_WORD_POP_CNT_EN.
- Defined: pop_cnt port exists. It increments by 1 on every cycle with sync_pop_req=1, including words discarded by flush. It wraps at 2^CNT_W and is cleared only by rst_n.
- Not defined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Package one_word_sync_pkg holds:
  - the FSM state encodings ST_IDLE=1'b0 and ST_ACK=1'b1;
  - the default DWID constant;
  - the counter-width constant shared with the push-side controller.
- One sub-module: ow_pop_fifo, a DEPTH-entry synchronous FIFO with write, read, flush, cnt, and head-data ports. The FSM lives in the top.

Test Plan:
- Single word: sync_pop_empty falls at T with sync_data=32'hA5A5_0001, m_ready=1 -> m_valid=1 and m_data=32'hA5A5_0001 at T+1; exactly one sync_pop_req pulse at T+1; fifo_cnt returns to 0 at T+2.
- Backpressure: m_ready=0, holder model delivers 3 words 32'h1, 32'h2, 32'h3 -> 2 words stored (fifo_cnt=2), third word not popped (no sync_pop_req). Raise m_ready -> words emerge in order 1, 2, 3, each with exactly one pop pulse.
- Full plus same-cycle read: fifo_cnt=2, holder word present, m_ready=1 -> capture allowed that cycle; fifo_cnt stays 2; sync_pop_req pulses next cycle.
- Flush collision: flush=1 in the capture cycle of word 32'hDEAD_BEEF -> fifo_cnt=0 next cycle; sync_pop_req still pulses once; m_valid stays 0.
- Async reset in ACK: drop rst_n mid-cycle while sync_pop_req=1 -> sync_pop_req=0 immediately and all outputs at reset values. After release with the holder still full -> word recaptured, one pulse.
- ONE_WORD_POP_CNT_EN with CNT_W=4: 17 words -> pop_cnt=1 (wrap). Build without the macro -> port absent and the other checks pass unchanged.
